// File: rtl/key_debounce_bank.sv
// Bank of independent key conditioners: synchronize, debounce, press-edge detect and
// stretch each raw board key into level / one-cycle press / minimum-width hold signals.

module key_debounce_lane #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int MIN_PULSE       = 4,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_hold,
    output logic rise
);
    localparam int   CW  = $clog2(DEBOUNCE_CYCLES);
    localparam int   SW  = $clog2(MIN_PULSE + 1);
    localparam logic REL = (ACTIVE_LOW != 0);

    logic [1:0]    sync;
    logic          s;
    logic          stable;
    logic [CW-1:0] cnt;
    logic [SW-1:0] str;

    // Synchronizer powers up at the released level so reset never reads as a press.
    assign s        = (ACTIVE_LOW != 0) ? ~sync[1] : sync[1];
    assign rise     = stable & ~key_level;
    assign key_hold = (str != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync      <= {2{REL}};
            stable    <= 1'b0;
            cnt       <= '0;
            key_level <= 1'b0;
            key_press <= 1'b0;
            str       <= '0;
        end else begin
            sync <= {sync[0], key_raw};
            // Any sample agreeing with the accepted state restarts the window.
            if (s == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable <= s;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            key_level <= stable;
            key_press <= rise;
            if (rise)
                str <= SW'(MIN_PULSE);
            else if (str != '0)
                str <= str - SW'(1);
        end
    end
endmodule

module key_debounce_bank #(
    parameter int N_KEYS          = 10,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int MIN_PULSE       = 4,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_hold,
    output logic              any_press
);
    logic [N_KEYS-1:0] rise;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_lane
        key_debounce_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .MIN_PULSE      (MIN_PULSE),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .key_raw  (key_raw[g]),
            .key_level(key_level[g]),
            .key_press(key_press[g]),
            .key_hold (key_hold[g]),
            .rise     (rise[g])
        );
    end

    // Registered from the same term as key_press so both land in one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) any_press <= 1'b0;
        else      any_press <= |rise;
    end
endmodule

// File: tb/tb_key_debounce_bank.sv
// Directed bench for key_debounce_bank: clean press, bounce, glitch/release,
// simultaneous keys, reset mid-hold, and re-press during stretch.
`timescale 1ns/1ps
module tb_key_debounce_bank;
    localparam int NK = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NK-1:0] key_raw  = '1;
    logic [NK-1:0] key_raw2 = '1;
    logic [NK-1:0] key_level, key_press, key_hold;
    logic [NK-1:0] key_level2, key_press2, key_hold2;
    logic          any_press, any_press2;

    int n_chk  = 0;
    int n_pass = 0;
    int press_cnt [NK];
    int hold_cnt  [NK];
    int any_cnt;
    logic [15:0] v_hold, v_press, v_level;

    always #5 clk = ~clk;

    key_debounce_bank #(.N_KEYS(NK), .DEBOUNCE_CYCLES(8), .MIN_PULSE(4), .ACTIVE_LOW(1)) dut (
        .clk(clk), .rst(rst), .key_raw(key_raw), .key_level(key_level),
        .key_press(key_press), .key_hold(key_hold), .any_press(any_press));

    key_debounce_bank #(.N_KEYS(NK), .DEBOUNCE_CYCLES(2), .MIN_PULSE(6), .ACTIVE_LOW(1)) dut2 (
        .clk(clk), .rst(rst), .key_raw(key_raw2), .key_level(key_level2),
        .key_press(key_press2), .key_hold(key_hold2), .any_press(any_press2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clr();
        for (int i = 0; i < NK; i++) begin
            press_cnt[i] = 0;
            hold_cnt[i]  = 0;
        end
        any_cnt = 0;
    endtask

    // Advance n edges; sample 1ns after each edge and accumulate pulse activity.
    task automatic tick(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NK; i++) begin
                if (key_press[i]) press_cnt[i]++;
                if (key_hold[i])  hold_cnt[i]++;
            end
            if (any_press) any_cnt++;
        end
    endtask

    initial begin
        clr();
        #1;
        chk("rst_level", 32'(key_level), 32'h0);
        chk("rst_press", 32'(key_press), 32'h0);
        chk("rst_hold",  32'(key_hold),  32'h0);
        chk("rst_any",   32'(any_press), 32'h0);
        tick(3);
        rst = 1'b1;
        tick(15);
        chk("idle_level", 32'(key_level), 32'h0);
        clr();

        // Clean press on key 0
        key_raw[0] = 1'b0;
        tick(10);
        chk("clean_pre_level", 32'(key_level[0]), 32'h0);
        tick(1);
        chk("clean_level", 32'(key_level[0]), 32'h1);
        chk("clean_press", 32'(key_press[0]), 32'h1);
        chk("clean_hold",  32'(key_hold[0]),  32'h1);
        chk("clean_any",   32'(any_press),    32'h1);
        tick(1);
        chk("clean_press_end", 32'(key_press[0]), 32'h0);
        tick(6);
        chk("clean_press_cnt", 32'(press_cnt[0]), 32'd1);
        chk("clean_hold_cnt",  32'(hold_cnt[0]),  32'd4);
        chk("clean_any_cnt",   32'(any_cnt),      32'd1);
        key_raw[0] = 1'b1;
        tick(15);
        chk("clean_release_press_cnt", 32'(press_cnt[0]), 32'd1);
        chk("clean_released", 32'(key_level[0]), 32'h0);
        clr();

        // Bounce on key 3: 3-cycle alternation never settles for 8 cycles
        for (int c = 0; c < 40; c++) begin
            key_raw[3] = ((c / 3) % 2) != 0;
            tick(1);
        end
        key_raw[3] = 1'b0;
        chk("bounce_quiet", 32'(press_cnt[3] + hold_cnt[3] + any_cnt), 32'd0);
        tick(10);
        chk("bounce_pre_level", 32'(key_level[3]), 32'h0);
        tick(1);
        chk("bounce_level", 32'(key_level[3]), 32'h1);
        tick(10);
        chk("bounce_press_cnt", 32'(press_cnt[3]), 32'd1);
        key_raw[3] = 1'b1;
        tick(15);
        clr();

        // Short glitch on key 5, then a long press and release
        key_raw[5] = 1'b0;
        tick(7);
        key_raw[5] = 1'b1;
        tick(15);
        chk("glitch_quiet", 32'(press_cnt[5] + hold_cnt[5] + any_cnt), 32'd0);
        chk("glitch_level", 32'(key_level[5]), 32'h0);
        key_raw[5] = 1'b0;
        tick(50);
        chk("long_level", 32'(key_level[5]), 32'h1);
        key_raw[5] = 1'b1;
        tick(10);
        chk("rel_pre_level", 32'(key_level[5]), 32'h1);
        tick(1);
        chk("rel_level", 32'(key_level[5]), 32'h0);
        tick(5);
        chk("rel_press_cnt", 32'(press_cnt[5]), 32'd1);
        chk("rel_hold_cnt",  32'(hold_cnt[5]),  32'd4);
        clr();

        // Simultaneous keys 1 and 8
        key_raw[1] = 1'b0;
        key_raw[8] = 1'b0;
        tick(11);
        chk("simul_press", 32'(key_press), 32'h102);
        chk("simul_any",   32'(any_press), 32'h1);
        tick(1);
        chk("simul_any_end", 32'(any_press), 32'h0);
        chk("simul_any_cnt", 32'(any_cnt),   32'd1);
        key_raw[1] = 1'b1;
        key_raw[8] = 1'b1;
        tick(15);
        clr();

        // Reset asserted during the 2nd cycle of key_hold[2]
        key_raw[2] = 1'b0;
        tick(11);
        chk("rh_hold1", 32'(key_hold[2]), 32'h1);
        tick(1);
        chk("rh_hold2", 32'(key_hold[2]), 32'h1);
        rst = 1'b0;
        #1;
        chk("rh_level", 32'(key_level), 32'h0);
        chk("rh_hold",  32'(key_hold),  32'h0);
        chk("rh_any",   32'(any_press), 32'h0);
        tick(3);
        rst = 1'b1;
        clr();
        tick(10);
        chk("rh_pre_press", 32'(press_cnt[2] + 32'(key_level[2])), 32'd0);
        tick(1);
        chk("rh_press",      32'(key_press[2]), 32'h1);
        chk("rh_hold_again", 32'(key_hold[2]),  32'h1);
        key_raw[2] = 1'b1;
        tick(15);
        clr();

        // Re-press during stretch on the DEBOUNCE=2 / MIN_PULSE=6 instance
        key_raw2[0] = 1'b0;
        tick(3);
        key_raw2[0] = 1'b1;
        tick(2);
        key_raw2[0] = 1'b0;
        v_hold = '0; v_press = '0; v_level = '0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) tick(1);
            v_hold[i]  = key_hold2[0];
            v_press[i] = key_press2[0];
            v_level[i] = key_level2[0];
        end
        chk("rep_hold",  32'(v_hold),  32'h07FF);
        chk("rep_press", 32'(v_press), 32'h0021);
        chk("rep_level", 32'(v_level), 32'hFFE7);
        chk("rep_other", 32'(key_hold2[NK-1:1]), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
